// File: rtl/switch_allocator.sv
// Switch allocator: round-robin arbitration of input head flits onto (output, VC) pairs,
// each pair held locked until its tail flit leaves. Optional watchdog under SA_WATCHDOG_EN.

module switch_allocator_vc #(
  parameter int NUM_IN   = 5,
  parameter int IW       = 3,
  parameter int WD_LIMIT = 255
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [NUM_IN-1:0] cand,
  input  logic              tail,
  input  logic              flit,
  output logic [IW-1:0]     sel,
  output logic              enable,
  output logic [NUM_IN-1:0] win,
  output logic              timeout
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     rr_q;
  logic [NUM_IN-1:0] rot;
  logic [IW-1:0]     off;
  logic [IW:0]       sum;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     rr_nxt;
  logic              found;
  logic              grant_now;
  logic              wd_hit;
  logic              to_d;

  // Rotate candidates so the pointer lands on bit 0; lowest set bit is the next in turn.
  assign rot = NUM_IN'({cand, cand} >> rr_q);

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = IW'(k);
      end
    end
  end

  assign sum       = {1'b0, rr_q} + {1'b0, off};
  assign win_idx   = (sum >= (IW+1)'(NUM_IN)) ? IW'(sum - (IW+1)'(NUM_IN)) : IW'(sum);
  assign rr_nxt    = (win_idx == IW'(NUM_IN - 1)) ? '0 : win_idx + 1'b1;
  assign grant_now = (state_q == IDLE) && found;
  assign enable    = (state_q == LOCKED);

  always_comb begin
    win = '0;
    if (grant_now) win[win_idx] = 1'b1;
  end

`ifdef SA_WATCHDOG_EN
  localparam int WD_W = ($clog2(WD_LIMIT + 1) > 8) ? $clog2(WD_LIMIT + 1) : 8;
  logic [WD_W-1:0] cnt_q;

  // Counts LOCKED cycles since the last flit (or since allocation).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                          cnt_q <= '0;
    else if (grant_now)                  cnt_q <= '0;
    else if (state_q == LOCKED && flit)  cnt_q <= '0;
    else if (state_q == LOCKED)          cnt_q <= cnt_q + 1'b1;
  end

  assign wd_hit = (state_q == LOCKED) && (cnt_q == WD_W'(WD_LIMIT));
`else
  logic unused_wd;
  assign unused_wd = flit ^ (WD_LIMIT == 0);
  assign wd_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE:   if (found) state_d = LOCKED;
      LOCKED: begin
        if (tail) begin
          state_d = IDLE;
        end else if (wd_hit) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // sel is only rewritten on a new allocation so the crossbar select never glitches in IDLE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sel     <= '0;
      rr_q    <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= to_d;
      if (grant_now) begin
        sel  <= win_idx;
        rr_q <= rr_nxt;
      end
    end
  end

endmodule

module switch_allocator #(
  parameter int NUM_IN   = 5,
  parameter int NUM_OUT  = 5,
  parameter int NUM_VCS  = 2,
  parameter int WD_LIMIT = 255,
  localparam int IW = (NUM_IN  > 1) ? $clog2(NUM_IN)  : 1,
  localparam int OW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
  localparam int VW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic                                 clk,
  input  logic                                 n_rst,
  input  logic [NUM_IN-1:0]                    req,
  input  logic [NUM_IN-1:0][OW-1:0]            req_out,
  input  logic [NUM_IN-1:0][VW-1:0]            req_vc,
  input  logic [NUM_OUT-1:0][NUM_VCS-1:0]      flit_sent,
  input  logic [NUM_OUT-1:0][NUM_VCS-1:0]      tail_sent,
  output logic [NUM_OUT-1:0][NUM_VCS-1:0][IW-1:0] sel,
  output logic [NUM_OUT-1:0][NUM_VCS-1:0]      enable,
  output logic [NUM_IN-1:0]                    grant,
  output logic [NUM_OUT-1:0][NUM_VCS-1:0]      wd_timeout
);

  logic [NUM_IN-1:0]                           held;
  logic [NUM_OUT-1:0][NUM_VCS-1:0][NUM_IN-1:0] cand;
  logic [NUM_OUT-1:0][NUM_VCS-1:0][NUM_IN-1:0] win;
  logic [NUM_IN-1:0]                           grant_d;

  // An input that already owns a pair may not win another one.
  always_comb begin
    held = '0;
    for (int o = 0; o < NUM_OUT; o++)
      for (int v = 0; v < NUM_VCS; v++)
        for (int i = 0; i < NUM_IN; i++)
          if (enable[o][v] && sel[o][v] == IW'(i)) held[i] = 1'b1;
  end

  // Out-of-range req_out/req_vc never match any pair and so drop out here.
  always_comb begin
    cand = '0;
    for (int o = 0; o < NUM_OUT; o++)
      for (int v = 0; v < NUM_VCS; v++)
        for (int i = 0; i < NUM_IN; i++)
          cand[o][v][i] = req[i] && !held[i] &&
                          (req_out[i] == OW'(o)) && (req_vc[i] == VW'(v));
  end

  for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
      switch_allocator_vc #(
        .NUM_IN  (NUM_IN),
        .IW      (IW),
        .WD_LIMIT(WD_LIMIT)
      ) u_vc (
        .clk    (clk),
        .n_rst  (n_rst),
        .cand   (cand[o][v]),
        .tail   (tail_sent[o][v]),
        .flit   (flit_sent[o][v]),
        .sel    (sel[o][v]),
        .enable (enable[o][v]),
        .win    (win[o][v]),
        .timeout(wd_timeout[o][v])
      );
    end
  end

  always_comb begin
    grant_d = '0;
    for (int o = 0; o < NUM_OUT; o++)
      for (int v = 0; v < NUM_VCS; v++)
        grant_d = grant_d | win[o][v];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) grant <= '0;
    else        grant <= grant_d;
  end

endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 SHALL have parameter NUM_IN, 5, number of input ports/buffers contending for outputs.
REQ-002 SHALL have parameter NUM_OUT, 5, number of crossbar output ports.
REQ-003 SHALL have parameter NUM_VCS, 2, virtual channels per output port.
REQ-004 SHALL have parameter WD_LIMIT, 255, watchdog threshold in cycles (used only under SA_WATCHDOG_EN).
REQ-005 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-006 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req  input  NUM_IN  input i holds an unallocated packet head flit.
REQ-008 SHALL have port req_out  input  NUM_IN x clog2(NUM_OUT)  requested output port per input.
REQ-009 SHALL have port req_vc  input  NUM_IN x clog2(NUM_VCS)  requested output VC per input.
REQ-010 SHALL have port flit_sent  input  NUM_OUT x NUM_VCS  pulse when any flit leaves on (o,v).
REQ-011 SHALL have port tail_sent  input  NUM_OUT x NUM_VCS  pulse when the tail flit leaves on (o,v).
REQ-012 SHALL have port sel  output  NUM_OUT x NUM_VCS x clog2(NUM_IN)  input index routed to (o,v); drives crossbar select.
REQ-013 SHALL have port enable  output  NUM_OUT x NUM_VCS  (o,v) allocated; drives crossbar enable.
REQ-014 SHALL have port grant  output  NUM_IN  one-cycle pulse to winning input.
REQ-015 SHALL have port wd_timeout  output  NUM_OUT x NUM_VCS  one-cycle pulse on forced release.

Function
REQ-016 SHALL keep per-(o,v) state: IDLE or LOCKED; enable[o][v] = (state == LOCKED), registered.
REQ-017 SHALL, in IDLE, consider inputs with req=1, req_out=o, req_vc=v, and no lock held by that input; inputs already holding a lock are masked.
REQ-018 SHALL pick the winner round-robin, searching from rr_ptr[o][v] upward modulo NUM_IN.
REQ-019 SHALL, for request at cycle t, present LOCKED, sel=winner, enable=1 and grant[winner]=1 at cycle t+1 (latency 1).
REQ-020 SHALL set rr_ptr[o][v] = (winner+1) mod NUM_IN on grant; hold it otherwise.
REQ-021 SHALL let distinct (o,v) pairs allocate independently in the same cycle; grant may have multiple bits set.
REQ-022 SHALL ignore requests with req_out >= NUM_OUT or req_vc >= NUM_VCS.
REQ-023 SHALL, in LOCKED, hold sel stable; tail_sent[o][v] -> IDLE next cycle (enable=0).
REQ-024 SHALL not re-arbitrate (o,v) in the cycle tail_sent is seen; earliest new enable is 2 cycles after tail_sent (one enable-low cycle).
REQ-025 SHALL ignore tail_sent and flit_sent on an IDLE (o,v).
REQ-026 SHALL retain sel value in IDLE (no glitch to crossbar).

Reset
REQ-027 SHALL on n_rst=0, asynchronously: all states IDLE, enable=0, sel=0, grant=0, rr_ptr=0, wd_timeout=0, watchdog counters 0.
REQ-028 SHALL on reset mid-packet drop all locks; no grant until first edge after n_rst deasserts.

Configuration
REQ-029 SHALL, with SA_WATCHDOG_EN defined, keep an 8-bit+ counter per (o,v): clear on allocation or flit_sent, increment each LOCKED cycle otherwise.
REQ-030 SHALL, with SA_WATCHDOG_EN, on counter reaching WD_LIMIT force IDLE next cycle and pulse wd_timeout[o][v] for one cycle.
REQ-031 SHALL, without SA_WATCHDOG_EN, synthesize no counters, tie wd_timeout to 0, ignore flit_sent.

Verification
REQ-032 Single request: req[2]=1, out=3, vc=1 at t -> t+1 enable[3][1]=1, sel[3][1]=2, grant=5'b00100.
REQ-033 Contention: inputs 0,1,4 request (1,0), rr_ptr=0 -> grants 0, then after each tail 1, then 4, then 0.
REQ-034 Release: tail_sent[3][1] at t with req[0] pending for (3,1) -> enable low t+1, enable=1 sel=0 at t+2.
REQ-035 Parallel: input 0 -> (2,0), input 1 -> (2,1) same cycle -> both enabled t+1, grant=5'b00011.
REQ-036 Lock mask: input 3 locked on (0,0) also requests (4,0) -> no grant for (4,0) until (0,0) released.
REQ-037 Watchdog (SA_WATCHDOG_EN, WD_LIMIT=255): lock (1,1), no flit_sent for 255 cycles -> wd_timeout[1][1] pulse, enable low next cycle; n_rst pulse mid-lock -> all enable=0 immediately.
